// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine initiator.
package gcd_pkg;

  localparam int GCD_W     = 8;
  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_FETCH  = 2'd3
  } state_t;

  typedef struct packed {
    logic [GCD_W-1:0] a;
    logic [GCD_W-1:0] b;
    logic [GCD_W-1:0] res;
  } entry_t;

endpackage

// File: rtl/gcd_res_buf.sv
// Two-entry result FIFO; head is always visible, storage resets to zero.
module gcd_res_buf
  import gcd_pkg::*;
#(
  parameter type T = entry_t
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  T           i_push_data,
  input  logic       i_pop,
  output T           o_head,
  output logic [1:0] o_count
);

  T           r_mem [BUF_DEPTH];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  // A pop in the same cycle frees the slot, so push at full is allowed then.
  assign w_push = i_push && ((r_count != 2'(BUF_DEPTH)) || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/gcd_master.sv
// Launches one GCD engine computation at a time, fetches the result and
// queues {a, b, gcd} for a downstream consumer; sticky timeout supervision.
module gcd_master
  import gcd_pkg::*;
#(
  parameter int W       = GCD_W,
  parameter int TIMEOUT = 255
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_a,
  input  logic [W-1:0] i_in_b,
  output logic [W-1:0] o_eng_a,
  output logic [W-1:0] o_eng_b,
  output logic         o_eng_start,
  input  logic         i_eng_res_rdy,
  input  logic [W-1:0] i_eng_res,
  output logic         o_eng_res_fetch,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_a,
  output logic [W-1:0] o_out_b,
  output logic [W-1:0] o_out_res,
  output logic         o_err_timeout,
  input  logic         i_clr_err
);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
  } ent_t;

  localparam int            TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_res;
  logic [TW-1:0] r_timer;
  logic          r_err;

  logic [1:0]    w_count;
  ent_t          w_head;
  ent_t          w_push_data;
  logic          w_accept;
  logic          w_pop;
  logic          w_to_hit;

  assign o_in_ready = (r_state == S_IDLE) && (w_count < 2'(BUF_DEPTH));
  assign w_accept   = i_in_valid && o_in_ready;
  // Fires on the step that takes the WAIT-cycle count to TIMEOUT, once per launch.
  assign w_to_hit   = (TIMEOUT != 0) && (r_state == S_WAIT) &&
                      (r_timer == TO_MAX - TW'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_timer <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_a     <= i_in_a;
          r_b     <= i_in_b;
          r_state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_timer != TO_MAX) r_timer <= r_timer + TW'(1);
          if (i_eng_res_rdy) begin
            r_res   <= i_eng_res;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        r_err <= 1'b0;
    else if (w_to_hit)   r_err <= 1'b1;
    else if (i_clr_err)  r_err <= 1'b0;
  end

  assign w_push_data = '{a: r_a, b: r_b, res: r_res};
  assign w_pop       = o_out_valid && i_out_ready;

  gcd_res_buf #(.T(ent_t)) u_buf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (r_state == S_FETCH),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign o_eng_a         = r_a;
  assign o_eng_b         = r_b;
  assign o_eng_start     = (r_state == S_LAUNCH);
  assign o_eng_res_fetch = (r_state == S_FETCH);
  assign o_out_valid     = (w_count != 2'd0);
  assign o_out_a         = w_head.a;
  assign o_out_b         = w_head.b;
  assign o_out_res       = w_head.res;
  assign o_err_timeout   = r_err;

endmodule

// File: tb/tb_gcd_master.sv
// Directed bench for gcd_master with a behavioural multicycle GCD engine.
module tb_gcd_master;

  localparam int W  = 8;
  localparam int TO = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W-1:0] eng_a, eng_b;
  logic         eng_start;
  logic         eng_res_rdy;
  logic [W-1:0] eng_res;
  logic         eng_res_fetch;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_a, out_b, out_res;
  logic         err_timeout;
  logic         clr_err = 1'b0;

  always #5 clk = ~clk;

  gcd_master #(.W(W), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_a(in_a), .i_in_b(in_b),
    .o_eng_a(eng_a), .o_eng_b(eng_b), .o_eng_start(eng_start),
    .i_eng_res_rdy(eng_res_rdy), .i_eng_res(eng_res), .o_eng_res_fetch(eng_res_fetch),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_a(out_a), .o_out_b(out_b), .o_out_res(out_res),
    .o_err_timeout(err_timeout), .i_clr_err(clr_err)
  );

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // Engine model: result ready lat cycles after the start pulse, held until fetch.
  int           lat = 5;
  bit           hang = 1'b0;
  logic         m_busy;
  int           m_cnt;
  logic [W-1:0] m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_cnt <= 0; m_a <= '0; m_b <= '0;
    end else if (eng_start) begin
      m_busy <= 1'b1; m_cnt <= lat - 1; m_a <= eng_a; m_b <= eng_b;
    end else if (eng_res_fetch) begin
      m_busy <= 1'b0;
    end else if (m_busy && m_cnt != 0 && !hang) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign eng_res_rdy = m_busy && (m_cnt == 0) && !hang;
  assign eng_res     = gcd_f(m_a, m_b);

  // Monitors sample just after the falling edge, when everything is settled.
  int               cyc = 0;
  int               start_q[$];
  int               fetch_cnt = 0;
  logic [3*W-1:0]   pop_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (eng_start)              start_q.push_back(cyc);
      if (eng_res_fetch)          fetch_cnt++;
      if (out_valid && out_ready) pop_q.push_back({out_a, out_b, out_res});
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    in_a = a; in_b = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    chk("accept_bound", 32'(n < 300), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_pops(input string name, input int target);
    int k;
    k = 0;
    while (pop_q.size() < target && k < 300) begin @(negedge clk); k++; end
    chk(name, pop_q.size(), target);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!out_valid && k < 300) begin @(negedge clk); k++; end
    chk(name, 32'(out_valid), 32'd1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int p0, s0, f0, k;

    vecs[0] = '{8'd12,  8'd8,  8'd4};
    vecs[1] = '{8'd7,   8'd0,  8'd7};
    vecs[2] = '{8'd255, 8'd85, 8'd85};
    vecs[3] = '{8'd0,   8'd5,  8'd5};
    vecs[4] = '{8'd9,   8'd9,  8'd9};
    vecs[5] = '{8'd100, 8'd64, 8'd4};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_eng_start", 32'(eng_start), 0);
    chk("rst_fetch", 32'(eng_res_fetch), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_eng_ab", 32'({eng_a, eng_b}), 0);
    chk("rst_out", 32'({out_a, out_b, out_res}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, held at the output
    s0 = start_q.size(); f0 = fetch_cnt;
    send(8'd48, 8'd18);
    chk("single_start_t1", 32'(eng_start), 1);
    chk("single_eng_a", 32'(eng_a), 48);
    chk("single_eng_b", 32'(eng_b), 18);
    wait_valid("single_valid");
    repeat (3) @(negedge clk);
    chk("single_starts", start_q.size(), s0 + 1);
    chk("single_fetches", fetch_cnt, f0 + 1);
    chk("single_out_a", 32'(out_a), 48);
    chk("single_out_b", 32'(out_b), 18);
    chk("single_out_res", 32'(out_res), 6);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("single_popped", 32'(out_valid), 0);

    // Back-to-back stream from the vector table
    out_ready = 1'b1;
    p0 = pop_q.size(); s0 = start_q.size();
    for (int i = 0; i < 6; i++) send(vecs[i].a, vecs[i].b);
    wait_pops("stream_count", p0 + 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("stream_entry%0d", i), 32'(pop_q[p0+i]), 32'({vecs[i].a, vecs[i].b, vecs[i].res}));
    // start s, ready s+5, fetch s+6, accept s+7, next start s+8
    for (int i = 1; i < 6; i++)
      chk($sformatf("stream_interval%0d", i), start_q[s0+i] - start_q[s0+i-1], 8);

    // Backpressure: two entries buffered, third request must wait
    out_ready = 1'b0;
    p0 = pop_q.size();
    send(8'd30, 8'd12);
    send(8'd35, 8'd21);
    k = 0;
    while (eng_res_fetch == 1'b0 && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    in_a = 8'd16; in_b = 8'd40; in_valid = 1'b1;
    s0 = start_q.size();
    repeat (20) @(negedge clk);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    chk("bp_no_start", start_q.size(), s0);
    chk("bp_head_res", 32'(out_res), 6);
    out_ready = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    in_valid = 1'b0;
    wait_pops("bp_count", p0 + 3);
    chk("bp_entry0", 32'(pop_q[p0]),   32'({8'd30, 8'd12, 8'd6}));
    chk("bp_entry1", 32'(pop_q[p0+1]), 32'({8'd35, 8'd21, 8'd7}));
    chk("bp_entry2", 32'(pop_q[p0+2]), 32'({8'd16, 8'd40, 8'd8}));

    // Push and pop in the same FETCH cycle
    out_ready = 1'b0;
    p0 = pop_q.size();
    send(8'd100, 8'd75);
    wait_valid("pp_first_valid");
    send(8'd45, 8'd27);
    k = 0;
    while (!eng_res_fetch && k < 50) begin @(negedge clk); k++; end
    chk("pp_fetch_seen", 32'(eng_res_fetch), 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pp_valid", 32'(out_valid), 1);
    chk("pp_head", 32'({out_a, out_b, out_res}), 32'({8'd45, 8'd27, 8'd9}));
    chk("pp_popped", pop_q.size(), p0 + 1);
    chk("pp_popped_entry", 32'(pop_q[p0]), 32'({8'd100, 8'd75, 8'd25}));
    out_ready = 1'b1;
    @(negedge clk);
    chk("pp_drained", 32'(out_valid), 0);

    // Timeout: engine stalls, flag is sticky, result still delivered
    p0 = pop_q.size();
    hang = 1'b1;
    send(8'd9, 8'd6);
    repeat (10) @(negedge clk);
    chk("to_before", 32'(err_timeout), 0);
    @(negedge clk);
    chk("to_at_t12", 32'(err_timeout), 1);
    repeat (5) @(negedge clk);
    chk("to_no_fetch", 32'(eng_res_fetch), 0);
    hang = 1'b0;
    wait_pops("to_delivered", p0 + 1);
    chk("to_entry", 32'(pop_q[p0]), 32'({8'd9, 8'd6, 8'd3}));
    chk("to_sticky", 32'(err_timeout), 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("to_cleared", 32'(err_timeout), 0);

    // Reset in WAIT, then a normal request
    hang = 1'b1;
    send(8'd50, 8'd20);
    repeat (3) @(negedge clk);
    f0 = fetch_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_start", 32'(eng_start), 0);
    chk("mid_rst_fetch", 32'(eng_res_fetch), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_eng_ab", 32'({eng_a, eng_b}), 0);
    chk("mid_rst_out", 32'({out_a, out_b, out_res}), 0);
    hang = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    p0 = pop_q.size();
    send(8'd21, 8'd14);
    wait_pops("post_rst_delivered", p0 + 1);
    chk("post_rst_entry", 32'(pop_q[p0]), 32'({8'd21, 8'd14, 8'd7}));
    chk("post_rst_fetches", fetch_cnt, f0 + 1);
    chk("post_rst_err", 32'(err_timeout), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
